// File: rtl/button_debouncer.sv
// Purpose: synchronise a raw push-button pin and only follow it after STABLE_CYCLES steady clocks.
// Latency: SYNC_STAGES + STABLE_CYCLES clocks from first sampling edge to level change; no backpressure (free-running input).
// Define BUTTON_GLITCH_CNT_EN to add the saturating glitch_count output.
module button_debouncer #(
    parameter int STABLE_CYCLES = 500000,
    parameter int SYNC_STAGES   = 2,
    parameter int GLITCH_W      = 8
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                button_in,
    output logic                level,
`ifdef BUTTON_GLITCH_CNT_EN
    output logic [GLITCH_W-1:0] glitch_count,
`endif
    output logic                busy
);

    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    generate
        if (STABLE_CYCLES < 1) begin : g_bad_stable
            $error("STABLE_CYCLES must be >= 1");
        end
        if (SYNC_STAGES < 2) begin : g_bad_sync
            $error("SYNC_STAGES must be >= 2");
        end
        if (GLITCH_W < 1) begin : g_bad_glitch
            $error("GLITCH_W must be >= 1");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE_LOW  = 2'd0,
        WAIT_HIGH = 2'd1,
        IDLE_HIGH = 2'd2,
        WAIT_LOW  = 2'd3
    } state_t;

    state_t                 state;
    logic [CNT_W-1:0]       cnt;
    logic [SYNC_STAGES-1:0] sync;
    logic                   s;

    // Only the first sync flop ever looks at the raw pin.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync <= '0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], button_in};
        end
    end

    assign s = sync[SYNC_STAGES-1];

    // An input change during WAIT wins over terminal count: abort without touching level.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE_LOW;
            cnt   <= '0;
            level <= 1'b0;
`ifdef BUTTON_GLITCH_CNT_EN
            glitch_count <= '0;
`endif
        end else begin
            case (state)
                IDLE_LOW: begin
                    if (s) begin
                        state <= WAIT_HIGH;
                        cnt   <= '0;
                    end
                end
                WAIT_HIGH: begin
                    if (!s) begin
                        state <= IDLE_LOW;
`ifdef BUTTON_GLITCH_CNT_EN
                        if (glitch_count != '1) glitch_count <= glitch_count + 1'b1;
`endif
                    end else if (cnt == CNT_LAST) begin
                        state <= IDLE_HIGH;
                        level <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                IDLE_HIGH: begin
                    if (!s) begin
                        state <= WAIT_LOW;
                        cnt   <= '0;
                    end
                end
                WAIT_LOW: begin
                    if (s) begin
                        state <= IDLE_HIGH;
`ifdef BUTTON_GLITCH_CNT_EN
                        if (glitch_count != '1) glitch_count <= glitch_count + 1'b1;
`endif
                    end else if (cnt == CNT_LAST) begin
                        state <= IDLE_LOW;
                        level <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE_LOW;
                    cnt   <= '0;
                end
            endcase
        end
    end

    assign busy = (state == WAIT_HIGH) || (state == WAIT_LOW);

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer with STABLE_CYCLES=4, SYNC_STAGES=2, GLITCH_W=2.
module tb_button_debouncer;

    logic clk = 1'b0;
    logic reset_n;
    logic button_in;
    logic level;
    logic busy;
`ifdef BUTTON_GLITCH_CNT_EN
    logic [1:0] glitch_count;
`endif

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    button_debouncer #(
        .STABLE_CYCLES(4),
        .SYNC_STAGES  (2),
        .GLITCH_W     (2)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .button_in   (button_in),
        .level       (level),
`ifdef BUTTON_GLITCH_CNT_EN
        .glitch_count(glitch_count),
`endif
        .busy        (busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset_n   = 1'b0;
        button_in = 1'b0;
        tick();
        tick();
        chk("reset_level", 32'(level), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        reset_n = 1'b1;

        // Idle low for 20 clocks
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("idle_level", 32'(level), 32'd0);
            chk("idle_busy", 32'(busy), 32'd0);
        end

        // Press: next posedge is E0, level must rise on E0+6
        button_in = 1'b1;
        tick();
        tick();
        chk("press_busy_e1", 32'(busy), 32'd0);
        tick();
        for (int e = 3; e <= 5; e++) begin
            tick();
            chk("press_busy_wait", 32'(busy), 32'd1);
            chk("press_level_wait", 32'(level), 32'd0);
        end
        tick();
        chk("press_level_e6", 32'(level), 32'd1);
        chk("press_busy_e6", 32'(busy), 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("press_hold_level", 32'(level), 32'd1);
        end

        // Release: level falls on E0+6
        button_in = 1'b0;
        for (int e = 0; e <= 5; e++) begin
            tick();
            chk("release_level_wait", 32'(level), 32'd1);
        end
        tick();
        chk("release_level_e6", 32'(level), 32'd0);
        chk("release_busy_e6", 32'(busy), 32'd0);
        for (int i = 0; i < 4; i++) tick();

        // Bounce 1,1,0,0,1,0 then low: two aborts, no level change
        button_in = 1'b1; tick(); chk("bounce_level", 32'(level), 32'd0);
        button_in = 1'b1; tick(); chk("bounce_level", 32'(level), 32'd0);
        button_in = 1'b0; tick(); chk("bounce_level", 32'(level), 32'd0);
        button_in = 1'b0; tick(); chk("bounce_level", 32'(level), 32'd0);
        button_in = 1'b1; tick(); chk("bounce_level", 32'(level), 32'd0);
        button_in = 1'b0; tick(); chk("bounce_level", 32'(level), 32'd0);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("bounce_settle_level", 32'(level), 32'd0);
        end
        chk("bounce_busy", 32'(busy), 32'd0);
`ifdef BUTTON_GLITCH_CNT_EN
        chk("bounce_glitch", 32'(glitch_count), 32'd2);
`endif

        // Press again and hold
        button_in = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        chk("repress_level", 32'(level), 32'd1);

        // 3-clock low pulse: WAIT_LOW aborts with cnt=2
        button_in = 1'b0;
        tick(); tick(); tick();
        button_in = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("pulse_level", 32'(level), 32'd1);
        end
        chk("pulse_busy", 32'(busy), 32'd0);
`ifdef BUTTON_GLITCH_CNT_EN
        chk("pulse_glitch", 32'(glitch_count), 32'd3);
`endif

        // Back to low, then reset during WAIT_HIGH with cnt=2
        button_in = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        chk("pre_reset_level", 32'(level), 32'd0);
        button_in = 1'b1;
        for (int e = 0; e <= 4; e++) tick();
        chk("pre_reset_busy", 32'(busy), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("async_reset_level", 32'(level), 32'd0);
        chk("async_reset_busy", 32'(busy), 32'd0);
`ifdef BUTTON_GLITCH_CNT_EN
        chk("async_reset_glitch", 32'(glitch_count), 32'd0);
`endif
        tick();
        reset_n = 1'b1;
        for (int e = 0; e <= 5; e++) begin
            tick();
            chk("post_reset_level_wait", 32'(level), 32'd0);
        end
        tick();
        chk("post_reset_level_e6", 32'(level), 32'd1);

        // Back to low, then five aborted presses
        button_in = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        chk("sat_start_level", 32'(level), 32'd0);
        for (int p = 0; p < 5; p++) begin
            button_in = 1'b1;
            tick(); tick();
            button_in = 1'b0;
            tick(); tick(); tick();
        end
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("sat_level", 32'(level), 32'd0);
        end
        chk("sat_busy", 32'(busy), 32'd0);
`ifdef BUTTON_GLITCH_CNT_EN
        chk("sat_glitch", 32'(glitch_count), 32'd3);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
